// File: rtl/nlp_fw_mag_peak.sv
// nlp_fw_mag_peak
//  Power-spectrum stage behind the 512-point NLP FFT. It reads each complex
//  bin (sign-magnitude, Q fractional bits) and computes
//  Fw = (|re|^2 >> Q) + (|im|^2 >> Q), saturated to the positive range. The
//  result is written to the Fw RAM.
//  With NLP_PEAK_SEARCH_EN defined, the block also tracks the largest Fw value
//  in MIN_BIN..MAX_BIN (gmax, gmax_bin) for the pitch search.
//  Without the macro, gmax is tied to 0 and gmax_bin to MIN_BIN.
//  Each bin takes 8 clocks: SET_ADDR RD_D1 RD_D2 LATCH SQUARE SUM WRITE INCR.
module nlp_fw_mag_peak #(
  parameter int N       = 80,
  parameter int Q       = 16,
  parameter int NBINS   = 256,
  parameter int MIN_BIN = 16,
  parameter int MAX_BIN = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [8:0]   fft_addr,
  input  logic [N-1:0] fft_real,
  input  logic [N-1:0] fft_imag,
  output logic [8:0]   fw_addr,
  output logic [N-1:0] fw_data,
  output logic         fw_wren,
  output logic [N-1:0] gmax,
  output logic [8:0]   gmax_bin,
  output logic         done,
  output logic         busy
);

  // Magnitude width (sign dropped), full square width, square after >> Q.
  localparam int MW = N - 1;
  localparam int PW = 2 * MW;
  localparam int SW = PW - Q;

  localparam logic [8:0]   MIN_BIN9 = 9'(MIN_BIN);
  localparam logic [8:0]   LAST_BIN = 9'(NBINS - 1);
  localparam logic [N-1:0] SAT_VAL  = {1'b0, {(N-1){1'b1}}};

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] SET_ADDR = 4'd1;
  localparam logic [3:0] RD_D1    = 4'd2;
  localparam logic [3:0] RD_D2    = 4'd3;
  localparam logic [3:0] LATCH    = 4'd4;
  localparam logic [3:0] SQUARE   = 4'd5;
  localparam logic [3:0] SUM      = 4'd6;
  localparam logic [3:0] WRITE    = 4'd7;
  localparam logic [3:0] INCR     = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  logic [3:0]   state_reg;
  logic [3:0]   state_next;
  logic [8:0]   bin_reg;
  logic [N-1:0] sum_reg;
  logic [SW:0]  sum_full;
  logic [N-1:0] sum_sat;

  // State register; an asserted reset drops straight back to IDLE mid-pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Fixed 8-state walk per bin; the last bin exits through DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = SET_ADDR;
      SET_ADDR: state_next = RD_D1;
      RD_D1:    state_next = RD_D2;
      RD_D2:    state_next = LATCH;
      LATCH:    state_next = SQUARE;
      SQUARE:   state_next = SUM;
      SUM:      state_next = WRITE;
      WRITE:    state_next = INCR;
      INCR:     state_next = (bin_reg == LAST_BIN) ? DONE : SET_ADDR;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Lane 0 carries the real part and lane 1 the imaginary part. Each lane
  // strips the sign, squares the magnitude and keeps the integer-aligned bits.
  for (genvar gi = 0; gi < 2; gi++) begin : lane_g
    logic [N-1:0]  din;
    logic [MW-1:0] mag_reg;
    logic [PW-1:0] sq_full;
    logic [SW-1:0] sq_reg;

    assign din     = (gi == 0) ? fft_real : fft_imag;
    assign sq_full = PW'(mag_reg) * PW'(mag_reg);

    // Capture the RAM data in LATCH and register the truncated square in SQUARE.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mag_reg <= '0;
        sq_reg  <= '0;
      end else begin
        if (state_reg == LATCH)  mag_reg <= din[N-2:0];
        if (state_reg == SQUARE) sq_reg  <= sq_full[PW-1:Q];
      end
    end
  end

  // Unsigned sum of both lanes, clamped so the sign bit of Fw is always 0.
  always_comb begin
    sum_full = {1'b0, lane_g[0].sq_reg} + {1'b0, lane_g[1].sq_reg};
    if (|sum_full[SW:N-1]) sum_sat = SAT_VAL;
    else                   sum_sat = {1'b0, sum_full[N-2:0]};
  end

  // Bin sequencing, RAM addressing, the Fw write strobe and the done/busy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_reg  <= '0;
      sum_reg  <= '0;
      fft_addr <= '0;
      fw_addr  <= '0;
      fw_data  <= '0;
      fw_wren  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      fw_wren <= 1'b0;
      done    <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            bin_reg <= '0;
          end
        end
        SET_ADDR: fft_addr <= bin_reg;
        SUM:      sum_reg  <= sum_sat;
        WRITE: begin
          fw_addr <= bin_reg;
          fw_data <= sum_reg;
          fw_wren <= 1'b1;
        end
        INCR: begin
          if (bin_reg != LAST_BIN) bin_reg <= bin_reg + 9'd1;
        end
        DONE:     busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef NLP_PEAK_SEARCH_EN
  logic in_band;

  assign in_band = (int'(bin_reg) >= MIN_BIN) && (int'(bin_reg) <= MAX_BIN);

  // Running peak over the search band. The strict compare keeps the lowest bin on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gmax     <= '0;
      gmax_bin <= MIN_BIN9;
    end else if (state_reg == IDLE && start) begin
      gmax     <= '0;
      gmax_bin <= MIN_BIN9;
    end else if (state_reg == WRITE && in_band && (sum_reg > gmax)) begin
      gmax     <= sum_reg;
      gmax_bin <= bin_reg;
    end
  end
`else
  assign gmax     = '0;
  assign gmax_bin = MIN_BIN9;
`endif

endmodule

// File: tb/tb_nlp_fw_mag_peak.sv
// Directed bench for nlp_fw_mag_peak: zero spectrum, single bin, sign handling,
// band edges and ties, saturation, start while busy, and reset mid-pass.
// The gmax expectations follow NLP_PEAK_SEARCH_EN the same way the design does.
module tb_nlp_fw_mag_peak;
  localparam int N = 80;
  localparam int Q = 16;
  localparam int NBINS = 256;
  localparam int MIN_BIN = 16;
  localparam int MAX_BIN = 128;
  localparam int LIMIT = 3000;

`ifdef NLP_PEAK_SEARCH_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  typedef logic [N-1:0] val_t;

  localparam val_t SIGN = 80'h8000_0000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [8:0]   fft_addr;
  logic [N-1:0] fft_real;
  logic [N-1:0] fft_imag;
  logic [8:0]   fw_addr;
  logic [N-1:0] fw_data;
  logic         fw_wren;
  logic [N-1:0] gmax;
  logic [8:0]   gmax_bin;
  logic         done;
  logic         busy;

  val_t mem_re [0:511];
  val_t mem_im [0:511];
  val_t exp_fw [0:511];
  val_t fw_mem [0:511];
  val_t rd1_re;
  val_t rd1_im;

  int wr_cnt = 0;
  int done_cnt = 0;
  int wren_dbl = 0;
  logic prev_wren = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  nlp_fw_mag_peak #(
    .N(N), .Q(Q), .NBINS(NBINS), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .fft_addr(fft_addr), .fft_real(fft_real), .fft_imag(fft_imag),
    .fw_addr(fw_addr), .fw_data(fw_data), .fw_wren(fw_wren),
    .gmax(gmax), .gmax_bin(gmax_bin), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // FFT output RAM with a two-clock read latency.
  always @(posedge clk) begin
    rd1_re   <= mem_re[fft_addr];
    rd1_im   <= mem_im[fft_addr];
    fft_real <= rd1_re;
    fft_imag <= rd1_im;
  end

  // Fw RAM model plus write/done counters, sampled on the falling edge.
  always @(negedge clk) begin
    prev_wren <= fw_wren;
    if (fw_wren) begin
      fw_mem[fw_addr] <= fw_data;
      wr_cnt <= wr_cnt + 1;
      if (prev_wren) wren_dbl <= wren_dbl + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input val_t got, input val_t exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
      exp_fw[i] = '0;
    end
  endtask

  // One full pass: start, wait for done, then check timing, writes and peak.
  task automatic run_pass(input int id, input bit poke, input val_t exp_gmax, input int exp_bin);
    int lat;
    int wr0;
    int d0;
    logic busy_mid;
    wr0 = wr_cnt;
    d0 = done_cnt;
    busy_mid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check_val($sformatf("p%0d busy_after_start", id), val_t'(busy), val_t'(1));
    while (done !== 1'b1 && lat < LIMIT) begin
      start = poke && (lat == 500);
      @(posedge clk); #1;
      lat++;
      if (lat == 1000) busy_mid = busy;
    end
    start = 1'b0;
    check_val($sformatf("p%0d done_latency", id), val_t'(lat), val_t'(8 * NBINS + 1));
    check_val($sformatf("p%0d busy_mid", id), val_t'(busy_mid), val_t'(1));
    @(posedge clk); #1;
    check_val($sformatf("p%0d done_width", id), val_t'(done), val_t'(0));
    check_val($sformatf("p%0d busy_end", id), val_t'(busy), val_t'(0));
    repeat (10) @(posedge clk);
    #1;
    check_val($sformatf("p%0d done_count", id), val_t'(done_cnt - d0), val_t'(1));
    check_val($sformatf("p%0d write_count", id), val_t'(wr_cnt - wr0), val_t'(NBINS));
    for (int i = 0; i < NBINS; i++)
      check_val($sformatf("p%0d fw[%0d]", id, i), fw_mem[i], exp_fw[i]);
    check_val($sformatf("p%0d gmax", id), gmax, PEAK_EN ? exp_gmax : val_t'(0));
    check_val($sformatf("p%0d gmax_bin", id), val_t'(gmax_bin),
              val_t'(PEAK_EN ? exp_bin : MIN_BIN));
    $display("pass %0d: lat=%0d writes=%0d gmax=0x%0h gmax_bin=%0d",
             id, lat, wr_cnt - wr0, gmax, gmax_bin);
  endtask

  // Outputs forced by an asserted reset.
  task automatic check_reset_outputs(input string tag);
    check_val({tag, " fw_wren"}, val_t'(fw_wren), val_t'(0));
    check_val({tag, " done"}, val_t'(done), val_t'(0));
    check_val({tag, " busy"}, val_t'(busy), val_t'(0));
    check_val({tag, " fft_addr"}, val_t'(fft_addr), val_t'(0));
    check_val({tag, " fw_addr"}, val_t'(fw_addr), val_t'(0));
    check_val({tag, " fw_data"}, fw_data, val_t'(0));
    check_val({tag, " gmax"}, gmax, val_t'(0));
    check_val({tag, " gmax_bin"}, val_t'(gmax_bin), val_t'(MIN_BIN));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w_rst;
    int d_rst;
    rst = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: all-zero spectrum
    run_pass(1, 1'b0, val_t'(0), MIN_BIN);

    // 2: single bin 40, 3.0 + j4.0 -> 25.0
    clear_mem();
    mem_re[40] = 80'h3_0000;
    mem_im[40] = 80'h4_0000;
    exp_fw[40] = 80'h19_0000;
    run_pass(2, 1'b0, 80'h19_0000, 40);

    // 3: negative parts -2.0 - j1.0 at bin 20 -> 5.0, then the positive twin
    clear_mem();
    mem_re[20] = SIGN | 80'h2_0000;
    mem_im[20] = SIGN | 80'h1_0000;
    exp_fw[20] = 80'h5_0000;
    run_pass(3, 1'b0, 80'h5_0000, 20);
    mem_re[20] = 80'h2_0000;
    mem_im[20] = 80'h1_0000;
    run_pass(4, 1'b0, 80'h5_0000, 20);

    // 4: tie 9.0 at bins 16 and 128; out-of-band 100.0 at 15 and 400.0 at 129
    clear_mem();
    mem_re[16]  = 80'h3_0000;
    mem_im[128] = 80'h3_0000;
    mem_re[15]  = 80'hA_0000;
    mem_re[129] = 80'h14_0000;
    exp_fw[16]  = 80'h9_0000;
    exp_fw[128] = 80'h9_0000;
    exp_fw[15]  = 80'h64_0000;
    exp_fw[129] = 80'h190_0000;
    run_pass(5, 1'b0, 80'h9_0000, 16);

    // 5: saturation at bin 50, then a repeat with start pulsed while busy
    clear_mem();
    mem_re[50] = 80'h7FFF_FFFF_FFFF_FFFF_0000;
    mem_im[50] = 80'h7FFF_FFFF_FFFF_FFFF_0000;
    exp_fw[50] = 80'h7FFF_FFFF_FFFF_FFFF_FFFF;
    run_pass(6, 1'b0, 80'h7FFF_FFFF_FFFF_FFFF_FFFF, 50);
    run_pass(7, 1'b1, 80'h7FFF_FFFF_FFFF_FFFF_FFFF, 50);

    // 6: reset while bin 100 is in flight, then a fresh complete pass
    clear_mem();
    mem_re[60] = 80'h5_0000;
    mem_re[99] = 80'h1_0000;
    exp_fw[60] = 80'h19_0000;
    exp_fw[99] = 80'h1_0000;
    d_rst = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 8 * 100 + 3) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("prerst fw_data", fw_data, 80'h1_0000);
    check_val("prerst fw_addr", val_t'(fw_addr), val_t'(99));
    check_val("prerst gmax", gmax, PEAK_EN ? val_t'(80'h19_0000) : val_t'(0));
    rst = 1'b0;
    w_rst = wr_cnt;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check_val("postrst writes", val_t'(wr_cnt - w_rst), val_t'(0));
    check_val("postrst done", val_t'(done_cnt - d_rst), val_t'(0));
    check_val("postrst busy", val_t'(busy), val_t'(0));
    $display("reset test: aborted at bin 100, writes_after=%0d", wr_cnt - w_rst);
    run_pass(8, 1'b0, 80'h19_0000, 60);

    check_val("fw_wren single cycle", val_t'(wren_dbl), val_t'(0));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
